// File: rtl/serdes_pkg.sv
// Shared definitions for the parallel2serial / serial2parallel link pair.
// Latency: n/a (types, constants and constant functions only).
// Backpressure: n/a.
package serdes_pkg;

    // Bit-order encoding for the MSB_FIRST parameter on both ends of the link.
    localparam bit ORDER_LSB_FIRST = 1'b0;
    localparam bit ORDER_MSB_FIRST = 1'b1;

    // Width of a bit counter that counts 0..width-1; never narrower than one bit.
    function automatic int cnt_w(input int width);
        return ($clog2(width) < 1) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/serial2parallel_if.sv
// Serial intake plus word valid/ready bundle for the deserializer.
// Latency: n/a (wiring only).
// Backpressure: dout_ready from the consumer; no backpressure toward the serial source.
interface serial2parallel_if #(
    parameter int WIDTH = 4
);
    logic             din;
    logic             din_valid;
    logic             sof;
    logic             dout_ready;
    logic             err_clr;
    logic [WIDTH-1:0] dout;
    logic             dout_valid;
    logic             overrun;
    logic             frame_err;

    // Environment side: drives the serial stream and consumes words.
    modport master (
        output din, din_valid, sof, dout_ready, err_clr,
        input  dout, dout_valid, overrun, frame_err
    );

    // Deserializer side.
    modport slave (
        input  din, din_valid, sof, dout_ready, err_clr,
        output dout, dout_valid, overrun, frame_err
    );
endinterface

// File: rtl/s2p_out_buf.sv
// Single-entry word holding register with valid/ready output and sticky overrun.
// Latency: word loaded at the completion edge, visible the following cycle.
// Backpressure: a new word arriving while full and not being consumed is dropped and flags overrun.
module s2p_out_buf #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_word,
    input  logic             i_ready,
    input  logic             i_err_clr,
    output logic [WIDTH-1:0] o_word,
    output logic             o_valid,
    output logic             o_overrun
);
    logic [WIDTH-1:0] r_word;
    logic             r_valid;
    logic             r_overrun;
    logic             w_drop;
    logic             w_accept;

    // A completed word is dropped only when the buffer is full and not draining this cycle.
    always_comb begin
        w_drop   = i_load & r_valid & ~i_ready;
        w_accept = i_load & ~w_drop;
    end

    // Buffer contents, valid flag and sticky overrun (a new drop beats err_clr).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_word    <= '0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            if (w_accept) begin
                r_word  <= i_word;
                r_valid <= 1'b1;
            end else if (r_valid && i_ready) begin
                r_valid <= 1'b0;
            end

            if (w_drop) begin
                r_overrun <= 1'b1;
            end else if (i_err_clr) begin
                r_overrun <= 1'b0;
            end
        end
    end

    assign o_word    = r_word;
    assign o_valid   = r_valid;
    assign o_overrun = r_overrun;
endmodule

// File: rtl/serial2parallel.sv
// Serial-to-parallel deserializer aligned by start-of-frame, feeding a one-word holding buffer.
// Latency: word visible on dout the cycle after its last valid bit is presented.
// Backpressure: holds one word against dout_ready=0; further completed words are dropped with overrun.
module serial2parallel
    import serdes_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = ORDER_MSB_FIRST
) (
    input  logic             clk,
    input  logic             rst,
    serial2parallel_if.slave bus
);
    localparam int            CW   = cnt_w(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_shift;
    logic             r_frame_err;

    logic             w_restart;
    logic             w_complete;
    logic [CW-1:0]    w_cnt_base;
    logic [CW-1:0]    w_cnt_next;
    logic [WIDTH-1:0] w_shift_base;
    logic [WIDTH-1:0] w_shift_next;
    logic [WIDTH-1:0] w_word;
    logic             w_valid;
    logic             w_overrun;

    // A mid-word sof throws away the partial word so this bit starts from a clean slate.
    always_comb begin
        w_restart    = bus.din_valid & bus.sof & (r_cnt != '0);
        w_cnt_base   = w_restart ? '0 : r_cnt;
        w_shift_base = w_restart ? '0 : r_shift;
        w_complete   = bus.din_valid & (w_cnt_base == LAST);
        w_cnt_next   = w_complete ? '0 : (w_cnt_base + CW'(1));
        if (MSB_FIRST == ORDER_MSB_FIRST) begin
            w_shift_next = {w_shift_base[WIDTH-2:0], bus.din};
        end else begin
            w_shift_next = {bus.din, w_shift_base[WIDTH-1:1]};
        end
    end

    // Bit intake advances only on qualified bits; frame_err is a one-cycle echo of a restart.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt       <= '0;
            r_shift     <= '0;
            r_frame_err <= 1'b0;
        end else begin
            r_frame_err <= w_restart;
            if (bus.din_valid) begin
                r_cnt   <= w_cnt_next;
                r_shift <= w_shift_next;
            end
        end
    end

    s2p_out_buf #(
        .WIDTH (WIDTH)
    ) u_out_buf (
        .clk       (clk),
        .rst       (rst),
        .i_load    (w_complete),
        .i_word    (w_shift_next),
        .i_ready   (bus.dout_ready),
        .i_err_clr (bus.err_clr),
        .o_word    (w_word),
        .o_valid   (w_valid),
        .o_overrun (w_overrun)
    );

    assign bus.dout       = w_word;
    assign bus.dout_valid = w_valid;
    assign bus.overrun    = w_overrun;
    assign bus.frame_err  = r_frame_err;
endmodule

// File: tb/tb_serial2parallel.sv
// Randomized plus directed bench for serial2parallel, MSB-first and LSB-first instances side by side.
// Latency: outputs compared 1 ns after every rising edge against a word-level reference model.
// Backpressure: dout_ready and err_clr driven from the stimulus alongside the serial stream.
module tb_serial2parallel;
    localparam int W = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic din = 1'b0;
    logic dv  = 1'b0;
    logic sof = 1'b0;
    logic rdy = 1'b0;
    logic clr = 1'b0;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state: bits gathered so far and the holding buffer as seen by the consumer.
    int           m_nbits;
    bit           m_bits[W];
    logic [W-1:0] m_dout_m;
    logic [W-1:0] m_dout_l;
    bit           m_vld;
    bit           m_ovr;
    bit           m_fe;

    serial2parallel_if #(.WIDTH(W)) bus_m ();
    serial2parallel_if #(.WIDTH(W)) bus_l ();

    assign bus_m.din        = din;
    assign bus_m.din_valid  = dv;
    assign bus_m.sof        = sof;
    assign bus_m.dout_ready = rdy;
    assign bus_m.err_clr    = clr;
    assign bus_l.din        = din;
    assign bus_l.din_valid  = dv;
    assign bus_l.sof        = sof;
    assign bus_l.dout_ready = rdy;
    assign bus_l.err_clr    = clr;

    serial2parallel #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
        .clk (clk),
        .rst (rst),
        .bus (bus_m.slave)
    );

    serial2parallel #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
        .clk (clk),
        .rst (rst),
        .bus (bus_l.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_nbits  = 0;
        m_dout_m = '0;
        m_dout_l = '0;
        m_vld    = 1'b0;
        m_ovr    = 1'b0;
        m_fe     = 1'b0;
        for (int i = 0; i < W; i++) m_bits[i] = 1'b0;
    endtask

    // Word-level view: list the bits of a frame, then weight them by arrival position.
    task automatic model_edge(input logic d, input logic v, input logic s, input logic r, input logic c);
        bit complete;
        bit drop;
        int wm;
        int wl;
        complete = 1'b0;
        drop     = 1'b0;
        m_fe     = 1'b0;
        wm       = 0;
        wl       = 0;
        if (v) begin
            if (s && m_nbits != 0) begin
                m_fe    = 1'b1;
                m_nbits = 0;
            end
            m_bits[m_nbits] = d;
            m_nbits++;
            if (m_nbits == W) begin
                complete = 1'b1;
                m_nbits  = 0;
                for (int i = 0; i < W; i++) begin
                    wm += int'(m_bits[i]) * (1 << (W - 1 - i));
                    wl += int'(m_bits[i]) * (1 << i);
                end
            end
        end
        if (complete) begin
            if (m_vld && !r) begin
                drop = 1'b1;
            end else begin
                m_vld    = 1'b1;
                m_dout_m = wm[W-1:0];
                m_dout_l = wl[W-1:0];
            end
        end else if (m_vld && r) begin
            m_vld = 1'b0;
        end
        if (drop) m_ovr = 1'b1;
        else if (c) m_ovr = 1'b0;
    endtask

    task automatic compare_all();
        chk("m_dout", bus_m.dout, m_dout_m);
        chk("m_vld",  bus_m.dout_valid, m_vld);
        chk("m_ovr",  bus_m.overrun, m_ovr);
        chk("m_fe",   bus_m.frame_err, m_fe);
        chk("l_dout", bus_l.dout, m_dout_l);
        chk("l_vld",  bus_l.dout_valid, m_vld);
        chk("l_ovr",  bus_l.overrun, m_ovr);
        chk("l_fe",   bus_l.frame_err, m_fe);
    endtask

    task automatic step(input logic d, input logic v, input logic s, input logic r, input logic c);
        din = d;
        dv  = v;
        sof = s;
        rdy = r;
        clr = c;
        @(posedge clk);
        model_edge(d, v, s, r, c);
        #1;
        compare_all();
    endtask

    // seq[W-1] is the first bit on the wire; sof accompanies it. Optional idle gap after the 2nd bit.
    task automatic send_seq(input logic [W-1:0] seq, input logic r, input int gap);
        for (int i = 0; i < W; i++) begin
            step(seq[W-1-i], 1'b1, (i == 0), r, 1'b0);
            if (i == 1) begin
                for (int g = 0; g < gap; g++) step(1'b0, 1'b0, 1'b0, r, 1'b0);
            end
        end
    endtask

    task automatic do_reset();
        din = 1'b0;
        dv  = 1'b0;
        sof = 1'b0;
        rdy = 1'b0;
        clr = 1'b0;
        rst = 1'b1;
        #1;
        model_reset();
        compare_all();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        logic [W-1:0] b2b[3];
        b2b[0] = 4'hA;
        b2b[1] = 4'h5;
        b2b[2] = 4'hF;

        do_reset();
        chk("rst_dout", bus_m.dout, 0);
        chk("rst_vld", bus_m.dout_valid, 0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Reset in the middle of a word.
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        do_reset();
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        send_seq(4'hB, 1'b1, 0);
        chk("rmw_dout", bus_m.dout, 4'hB);
        chk("rmw_vld", bus_m.dout_valid, 1);
        chk("rmw_ovr", bus_m.overrun, 0);
        chk("rmw_fe", bus_m.frame_err, 0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        // Basic word, both bit orders.
        send_seq(4'hB, 1'b1, 0);
        chk("basic_dout_m", bus_m.dout, 4'hB);
        chk("basic_dout_l", bus_l.dout, 4'hD);
        chk("basic_vld", bus_m.dout_valid, 1);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("basic_vld_once", bus_m.dout_valid, 0);

        // Idle gap inside a word.
        send_seq(4'hB, 1'b1, 3);
        chk("gap_dout", bus_m.dout, 4'hB);
        chk("gap_vld", bus_m.dout_valid, 1);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        // Backpressure then overrun, then drain with err_clr.
        send_seq(4'hB, 1'b0, 0);
        send_seq(4'h6, 1'b0, 0);
        chk("ovr_dout", bus_m.dout, 4'hB);
        chk("ovr_vld", bus_m.dout_valid, 1);
        chk("ovr_flag", bus_m.overrun, 1);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        chk("drain_vld", bus_m.dout_valid, 0);
        chk("drain_ovr", bus_m.overrun, 0);

        // Framing error: partial 1,0 then a fresh frame 1,1,0,0.
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        chk("fe_pulse", bus_m.frame_err, 1);
        chk("fe_no_vld", bus_m.dout_valid, 0);
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        chk("fe_one_cycle", bus_m.frame_err, 0);
        step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        chk("fe_dout_m", bus_m.dout, 4'hC);
        chk("fe_dout_l", bus_l.dout, 4'h3);

        // Back-to-back words with the consumer always ready.
        for (int k = 0; k < 3; k++) begin
            send_seq(b2b[k], 1'b1, 0);
            chk("b2b_dout", bus_m.dout, b2b[k]);
            chk("b2b_vld", bus_m.dout_valid, 1);
            chk("b2b_ovr", bus_m.overrun, 0);
        end
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        // Random traffic: gaps, stray sof, backpressure, overrun clears.
        for (int n = 0; n < 600; n++) begin
            step(1'($urandom_range(0, 1)),
                 ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 2) != 0),
                 ($urandom_range(0, 7) == 0));
        end

        // Random reset in flight, then clean traffic again.
        do_reset();
        for (int n = 0; n < 200; n++) begin
            step(1'($urandom_range(0, 1)), 1'b1, ($urandom_range(0, 15) == 0), 1'b1, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
